// File: rtl/vgpr_rd_port_arbiter.sv
// vgpr_rd_port_arbiter: round-robin arbiter driving the VGPR 8-to-1 read-port mux, with return tagging
module vgpr_rd_port_arbiter #(
    parameter int NUM_PORTS  = 8,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 2048,
    parameter int RD_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic                        stall,
    output logic [NUM_PORTS-1:0]        gnt,
    output logic [NUM_PORTS-1:0]        port_rd_en,
    output logic [NUM_PORTS*ADDR_W-1:0] port_rd_addr,
    input  logic [DATA_W-1:0]           rd_data_in,
    output logic [NUM_PORTS-1:0]        resp_valid,
    output logic [DATA_W-1:0]           resp_data,
    output logic                        busy
);
    localparam int PW = $clog2(NUM_PORTS);

    logic [PW-1:0]               rr_ptr;
    logic [PW-1:0]               gnt_idx;
    logic [PW-1:0]               idx;
    logic                        found;
    logic [NUM_PORTS*ADDR_W-1:0] addr_nxt;
    logic [NUM_PORTS-1:0]        tag [RD_LATENCY];
    logic [2:0]                  outstanding;

    // first requester at or above rr_ptr wins, wrapping; nothing is granted in reset or stall
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        idx     = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = rr_ptr + PW'(k);
            if (rst && !stall && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                found    = 1'b1;
            end
        end
    end

    // only the granted port's address field survives; all others read as zero
    always_comb begin
        addr_nxt = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            addr_nxt[i*ADDR_W +: ADDR_W] = gnt[i] ? req_addr[i*ADDR_W +: ADDR_W] : '0;
    end

    // issue stage: pointer advance past the winner and register the mux-facing enables/addresses
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr       <= '0;
            port_rd_en   <= '0;
            port_rd_addr <= '0;
        end else begin
            rr_ptr       <= found ? gnt_idx + PW'(1) : rr_ptr;
            port_rd_en   <= gnt;
            port_rd_addr <= addr_nxt;
        end
    end

    // return stage: enables ride a shift pipeline so data comes back tagged with its owner
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < RD_LATENCY; i++)
                tag[i] <= '0;
        end else begin
            tag[0] <= port_rd_en;
            for (int i = 1; i < RD_LATENCY; i++)
                tag[i] <= tag[i-1];
        end
    end

    // count of reads past the issue edge whose response has not yet been consumed
    always_ff @(posedge clk) begin
        if (!rst)
            outstanding <= '0;
        else
            outstanding <= outstanding + 3'(|port_rd_en) - 3'(|resp_valid);
    end

    assign resp_valid = tag[RD_LATENCY-1];
    assign resp_data  = rd_data_in;
    // a read on the enables this cycle is already in flight even before the counter sees it
    assign busy       = (outstanding != 3'd0) || (|port_rd_en);

    a_en_onehot:   assert property (@(posedge clk) disable iff (!rst) $onehot0(port_rd_en));
    a_resp_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(resp_valid));
    a_outstanding: assert property (@(posedge clk) disable iff (!rst) int'(outstanding) <= RD_LATENCY + 1);
endmodule
